// File: rtl/hazard_stall_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_stall_ctrl_pkg
// Purpose  : Pipeline-wide opcode constants, control FSM encoding, register match helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_stall_ctrl_pkg;

    localparam logic [1:0] c_StRun    = 2'd0;
    localparam logic [1:0] c_StStall2 = 2'd1;
    localparam logic [1:0] c_StFlush  = 2'd2;

    localparam logic [5:0] c_OpRtype  = 6'h00;
    localparam logic [5:0] c_OpRegimm = 6'h01;
    localparam logic [5:0] c_OpJ      = 6'h02;
    localparam logic [5:0] c_OpJal    = 6'h03;
    localparam logic [5:0] c_OpBeq    = 6'h04;
    localparam logic [5:0] c_OpBne    = 6'h05;
    localparam logic [5:0] c_OpBlez   = 6'h06;
    localparam logic [5:0] c_OpBgtz   = 6'h07;
    localparam logic [5:0] c_OpSw     = 6'h2B;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (dst != 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_detect.sv
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational classification of IF/ID against ID/EX and EX/MEM hazards
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_rsAddr,
    input  logic [4:0] i_rtAddr,
    input  logic [4:0] i_rdAddrIdex,
    input  logic       i_regWriteIdex,
    input  logic       i_memReadIdex,
    input  logic [4:0] i_rdAddrExmem,
    input  logic       i_memReadExmem,
    output logic       o_loadUse,
    output logic       o_branchAlu,
    output logic       o_branchLoadLate,
    output logic       o_branchLoadEarly,
    output logic       o_isJmp
);

    logic w_isBrRR;
    logic w_isBrR;
    logic w_isBranch;
    logic w_usesRt;
    logic w_rsMatchIdex;
    logic w_rtMatchIdex;
    logic w_rsMatchExmem;
    logic w_rtMatchExmem;
    logic w_brSrcIdex;
    logic w_brSrcExmem;

    assign w_isBrRR   = (i_opcode == c_OpBeq) || (i_opcode == c_OpBne);
    assign w_isBrR    = (i_opcode == c_OpRegimm) || (i_opcode == c_OpBlez) ||
                        (i_opcode == c_OpBgtz);
    assign w_isBranch = w_isBrRR || w_isBrR;
    assign w_usesRt   = w_isBrRR || (i_opcode == c_OpRtype) || (i_opcode == c_OpSw);
    assign o_isJmp    = (i_opcode == c_OpJ) || (i_opcode == c_OpJal);

    assign w_rsMatchIdex  = regMatch(i_rsAddr, i_rdAddrIdex);
    assign w_rtMatchIdex  = regMatch(i_rtAddr, i_rdAddrIdex);
    assign w_rsMatchExmem = regMatch(i_rsAddr, i_rdAddrExmem);
    assign w_rtMatchExmem = regMatch(i_rtAddr, i_rdAddrExmem);

    // Branches resolve in ID, so only the sources the branch actually reads matter.
    assign w_brSrcIdex  = w_isBranch && (w_rsMatchIdex  || (w_isBrRR && w_rtMatchIdex));
    assign w_brSrcExmem = w_isBranch && (w_rsMatchExmem || (w_isBrRR && w_rtMatchExmem));

    assign o_loadUse         = i_memReadIdex && (w_rsMatchIdex || (w_usesRt && w_rtMatchIdex));
    assign o_branchAlu       = w_brSrcIdex && i_regWriteIdex && !i_memReadIdex;
    assign o_branchLoadLate  = w_brSrcExmem && i_memReadExmem;
    assign o_branchLoadEarly = w_brSrcIdex && i_memReadIdex;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Stall/flush control FSM for an ID-stage-branch pipeline, with perf counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Opcode,
    input  logic [4:0]       RsAddr_IFID,
    input  logic [4:0]       RtAddr_IFID,
    input  logic [4:0]       RdAddr_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic             MemRead_IDEX,
    input  logic [4:0]       RdAddr_EXMEM,
    input  logic             MemRead_EXMEM,
    input  logic             BranchTaken,
    input  logic             Freeze,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       State
);

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    logic w_loadUse;
    logic w_branchAlu;
    logic w_branchLoadLate;
    logic w_branchLoadEarly;
    logic w_isJmp;
    logic w_anyHazard;
    logic w_stall;
    logic w_redirect;

    hazard_detect u_detect (
        .i_opcode          (Opcode),
        .i_rsAddr          (RsAddr_IFID),
        .i_rtAddr          (RtAddr_IFID),
        .i_rdAddrIdex      (RdAddr_IDEX),
        .i_regWriteIdex    (RegWrite_IDEX),
        .i_memReadIdex     (MemRead_IDEX),
        .i_rdAddrExmem     (RdAddr_EXMEM),
        .i_memReadExmem    (MemRead_EXMEM),
        .o_loadUse         (w_loadUse),
        .o_branchAlu       (w_branchAlu),
        .o_branchLoadLate  (w_branchLoadLate),
        .o_branchLoadEarly (w_branchLoadEarly),
        .o_isJmp           (w_isJmp)
    );

    assign w_anyHazard = w_loadUse || w_branchAlu || w_branchLoadLate || w_branchLoadEarly;

    // FLUSH evaluates hazards like RUN; only STALL2 stalls unconditionally.
    assign w_stall    = (r_state == c_StStall2) || w_anyHazard;
    // A redirect is only meaningful once the branch has resolved (no stall).
    assign w_redirect = (r_state == c_StRun) && !w_stall && (BranchTaken || w_isJmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_StRun;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (!Freeze) begin
            case (r_state)
                c_StRun, c_StFlush: begin
                    if (w_branchLoadEarly) begin
                        w_nextState = c_StStall2;
                    end else if (w_redirect) begin
                        w_nextState = c_StFlush;
                    end else begin
                        w_nextState = c_StRun;
                    end
                end
                c_StStall2: w_nextState = c_StRun;
                default:    w_nextState = c_StRun;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        if (rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            IFIDFlush  = 1'b1;
        end else if (Freeze) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
        end else begin
            PCWrite    = !w_stall;
            IFIDWrite  = !w_stall;
            IDEXBubble = w_stall;
            IFIDFlush  = w_redirect;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else if (!Freeze) begin
            if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            if (w_redirect && (r_flushCount != {CNT_W{1'b1}})) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

    assign StallCount = r_stallCount;
    assign FlushCount = r_flushCount;
    assign State      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed table-driven and sequence checks for hazard_stall_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;
    localparam logic [1:0] c_Run = 2'd0, c_Stall2 = 2'd1, c_Flush = 2'd2;

    logic             clk;
    logic             rst;
    logic [5:0]       Opcode;
    logic [4:0]       RsAddr_IFID, RtAddr_IFID, RdAddr_IDEX, RdAddr_EXMEM;
    logic             RegWrite_IDEX, MemRead_IDEX, MemRead_EXMEM, BranchTaken, Freeze;
    logic             PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
    logic [CNT_W-1:0] StallCount, FlushCount;
    logic [1:0]       State;
    logic [3:0]       w_outs;

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .Opcode        (Opcode),
        .RsAddr_IFID   (RsAddr_IFID),
        .RtAddr_IFID   (RtAddr_IFID),
        .RdAddr_IDEX   (RdAddr_IDEX),
        .RegWrite_IDEX (RegWrite_IDEX),
        .MemRead_IDEX  (MemRead_IDEX),
        .RdAddr_EXMEM  (RdAddr_EXMEM),
        .MemRead_EXMEM (MemRead_EXMEM),
        .BranchTaken   (BranchTaken),
        .Freeze        (Freeze),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEXBubble    (IDEXBubble),
        .IFIDFlush     (IFIDFlush),
        .StallCount    (StallCount),
        .FlushCount    (FlushCount),
        .State         (State)
    );

    assign w_outs = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rdI;
        logic       rw;
        logic       mr;
        logic [4:0] rdE;
        logic       mrE;
        logic       bt;
        logic       fz;
        logic [3:0] expOut;   // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}
        logic [1:0] expState;
        logic [3:0] expSc;
        logic [3:0] expFc;
        string      name;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rdI, input logic rw, input logic mr,
                         input logic [4:0] rdE, input logic mrE, input logic bt,
                         input logic fz);
        Opcode = op; RsAddr_IFID = rs; RtAddr_IFID = rt;
        RdAddr_IDEX = rdI; RegWrite_IDEX = rw; MemRead_IDEX = mr;
        RdAddr_EXMEM = rdE; MemRead_EXMEM = mrE; BranchTaken = bt; Freeze = fz;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        setIn(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        //                op     rs     rt     rdI  rw  mr  rdE   mrE  bt  fz  out      state     sc    fc
        vecs[0]  = '{6'h00, 5'd1, 5'd2,  5'd0, 0, 0, 5'd0,  0, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "nop"};
        vecs[1]  = '{6'h00, 5'd2, 5'd3,  5'd2, 1, 1, 5'd0,  0, 0, 0, 4'b0010, c_Run,    4'd1, 4'd0, "lu_rs"};
        vecs[2]  = '{6'h00, 5'd1, 5'd2,  5'd2, 1, 1, 5'd0,  0, 0, 0, 4'b0010, c_Run,    4'd1, 4'd0, "lu_rt_rtype"};
        vecs[3]  = '{6'h23, 5'd1, 5'd2,  5'd2, 1, 1, 5'd0,  0, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "lu_rt_lw"};
        vecs[4]  = '{6'h2B, 5'd1, 5'd2,  5'd2, 1, 1, 5'd0,  0, 0, 0, 4'b0010, c_Run,    4'd1, 4'd0, "lu_rt_sw"};
        vecs[5]  = '{6'h00, 5'd0, 5'd0,  5'd0, 1, 1, 5'd0,  0, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "lu_r0"};
        vecs[6]  = '{6'h04, 5'd5, 5'd6,  5'd6, 1, 0, 5'd0,  0, 1, 0, 4'b0010, c_Run,    4'd1, 4'd0, "br_alu_bt"};
        vecs[7]  = '{6'h00, 5'd5, 5'd1,  5'd5, 1, 0, 5'd0,  0, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "alu_rtype"};
        vecs[8]  = '{6'h05, 5'd7, 5'd8,  5'd0, 0, 0, 5'd8,  1, 0, 0, 4'b0010, c_Run,    4'd1, 4'd0, "br_late"};
        vecs[9]  = '{6'h01, 5'd9, 5'd10, 5'd0, 0, 0, 5'd10, 1, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "brr_rt_late"};
        vecs[10] = '{6'h06, 5'd4, 5'd0,  5'd4, 1, 1, 5'd0,  0, 0, 0, 4'b0010, c_Stall2, 4'd1, 4'd0, "br_early"};
        vecs[11] = '{6'h04, 5'd1, 5'd2,  5'd0, 0, 0, 5'd0,  0, 1, 0, 4'b1101, c_Flush,  4'd0, 4'd1, "br_taken"};
        vecs[12] = '{6'h02, 5'd0, 5'd0,  5'd0, 0, 0, 5'd0,  0, 0, 0, 4'b1101, c_Flush,  4'd0, 4'd1, "jmp"};
        vecs[13] = '{6'h03, 5'd0, 5'd0,  5'd0, 0, 0, 5'd0,  0, 0, 0, 4'b1101, c_Flush,  4'd0, 4'd1, "jal"};
        vecs[14] = '{6'h00, 5'd2, 5'd3,  5'd2, 1, 1, 5'd0,  0, 0, 1, 4'b0000, c_Run,    4'd0, 4'd0, "frz_lu"};
        vecs[15] = '{6'h04, 5'd1, 5'd2,  5'd0, 0, 0, 5'd0,  0, 1, 1, 4'b0000, c_Run,    4'd0, 4'd0, "frz_bt"};
        vecs[16] = '{6'h04, 5'd0, 5'd1,  5'd0, 0, 0, 5'd0,  1, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "late_r0"};
        vecs[17] = '{6'h07, 5'd3, 5'd0,  5'd3, 1, 0, 5'd0,  0, 0, 0, 4'b0010, c_Run,    4'd1, 4'd0, "bgtz_alu"};
        vecs[18] = '{6'h04, 5'd3, 5'd4,  5'd4, 0, 0, 5'd0,  0, 0, 0, 4'b1100, c_Run,    4'd0, 4'd0, "br_nowrite"};
        vecs[19] = '{6'h05, 5'd1, 5'd6,  5'd6, 1, 1, 5'd0,  0, 0, 0, 4'b0010, c_Stall2, 4'd1, 4'd0, "bne_rt_early"};
        vecs[20] = '{6'h02, 5'd2, 5'd0,  5'd2, 1, 1, 5'd0,  0, 0, 0, 4'b0010, c_Run,    4'd1, 4'd0, "jmp_lu"};

        rst = 1'b1;
        setIn(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_outs", 32'(w_outs), 32'b0011);
        step();
        check("rst_state", 32'(State), 32'(c_Run));
        check("rst_sc", 32'(StallCount), 32'd0);
        check("rst_fc", 32'(FlushCount), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            doReset();
            setIn(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rdI, vecs[i].rw, vecs[i].mr,
                  vecs[i].rdE, vecs[i].mrE, vecs[i].bt, vecs[i].fz);
            check({vecs[i].name, "_outs"}, 32'(w_outs), 32'(vecs[i].expOut));
            step();
            check({vecs[i].name, "_state"}, 32'(State), 32'(vecs[i].expState));
            check({vecs[i].name, "_sc"}, 32'(StallCount), 32'(vecs[i].expSc));
            check({vecs[i].name, "_fc"}, 32'(FlushCount), 32'(vecs[i].expFc));
        end

        // lw $3 ahead of beq on $3: two stall cycles, RUN -> STALL2 -> RUN
        doReset();
        setIn(6'h04, 5'd3, 5'd1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("early_c0_outs", 32'(w_outs), 32'b0010);
        check("early_c0_state", 32'(State), 32'(c_Run));
        step();
        check("early_c1_state", 32'(State), 32'(c_Stall2));
        setIn(6'h04, 5'd3, 5'd1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("early_c1_outs", 32'(w_outs), 32'b0010);
        step();
        check("early_c2_state", 32'(State), 32'(c_Run));
        check("early_sc", 32'(StallCount), 32'd2);
        setIn(6'h04, 5'd3, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("early_c2_outs", 32'(w_outs), 32'b1100);

        // Taken branch, then jump; FLUSH drops IFIDFlush even with BranchTaken high
        doReset();
        setIn(6'h04, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("bj_br_outs", 32'(w_outs), 32'b1101);
        step();
        check("bj_br_state", 32'(State), 32'(c_Flush));
        check("bj_flush_outs", 32'(w_outs), 32'b1100);
        step();
        check("bj_back_state", 32'(State), 32'(c_Run));
        setIn(6'h02, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("bj_j_outs", 32'(w_outs), 32'b1101);
        step();
        check("bj_j_state", 32'(State), 32'(c_Flush));
        check("bj_fc", 32'(FlushCount), 32'd2);
        setIn(6'h00, 5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("flush_lu_outs", 32'(w_outs), 32'b0010);
        step();
        check("flush_lu_state", 32'(State), 32'(c_Run));
        check("flush_lu_sc", 32'(StallCount), 32'd1);

        // Freeze while in STALL2 holds state and counters
        doReset();
        setIn(6'h06, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("frz_enter_state", 32'(State), 32'(c_Stall2));
        setIn(6'h06, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        check("frz_outs", 32'(w_outs), 32'b0000);
        step();
        step();
        check("frz_hold_state", 32'(State), 32'(c_Stall2));
        check("frz_hold_sc", 32'(StallCount), 32'd1);
        check("frz_hold_fc", 32'(FlushCount), 32'd0);
        Freeze = 1'b0;
        #1;
        check("frz_rel_outs", 32'(w_outs), 32'b0010);
        step();
        check("frz_rel_state", 32'(State), 32'(c_Run));
        check("frz_rel_sc", 32'(StallCount), 32'd2);

        // Reset taken while in STALL2 with StallCount=5, Freeze also high
        doReset();
        setIn(6'h06, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        check("rs2_pre_state", 32'(State), 32'(c_Stall2));
        check("rs2_pre_sc", 32'(StallCount), 32'd5);
        rst = 1'b1;
        Freeze = 1'b1;
        #1;
        check("rs2_outs", 32'(w_outs), 32'b0011);
        step();
        check("rs2_state", 32'(State), 32'(c_Run));
        check("rs2_sc", 32'(StallCount), 32'd0);
        rst = 1'b0;
        Freeze = 1'b0;

        // Counter saturation at all-ones
        doReset();
        setIn(6'h00, 5'd2, 5'd3, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step();
        check("sat_sc", 32'(StallCount), 32'd15);
        check("sat_state", 32'(State), 32'(c_Run));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port Opcode, input, 6: opcode of the instruction in IF/ID.
REQ-005 SHALL have ports RsAddr_IFID and RtAddr_IFID, input, 5 each: source registers of the instruction in IF/ID.
REQ-006 SHALL have ports RdAddr_IDEX, RegWrite_IDEX and MemRead_IDEX, input, 5/1/1: destination, write enable and load flag of the instruction in ID/EX.
REQ-007 SHALL have ports RdAddr_EXMEM and MemRead_EXMEM, input, 5/1: destination and load flag of the instruction in EX/MEM.
REQ-008 SHALL have port BranchTaken, input, 1: ID-stage branch/compare resolved taken.
REQ-009 SHALL have port Freeze, input, 1: external pipeline hold, e.g. memory wait.
REQ-010 SHALL have ports PCWrite and IFIDWrite, output, 1 each: enables for the PC and IF/ID registers.
REQ-011 SHALL have port IDEXBubble, output, 1: inserts a NOP into ID/EX by zeroing its control bits.
REQ-012 SHALL have port IFIDFlush, output, 1: clears IF/ID to a NOP.
REQ-013 SHALL have ports StallCount and FlushCount, output, CNT_W each: saturating performance counters.
REQ-014 SHALL have port State, output, 2: current FSM state, with encoding RUN=0, STALL2=1, FLUSH=2.

Function
REQ-015 SHALL classify Opcode as follows: BrRR = 0x04/0x05 (uses rs and rt); BrR = 0x01/0x06/0x07 (uses rs); Jmp = 0x02/0x03; UsesRt = BrRR or R-type (0x00) or store (0x2B).
REQ-016 SHALL define a match as the source equals the destination and the destination is not 0.
REQ-017 SHALL raise a load-use hazard when MemRead_IDEX is 1 and RdAddr_IDEX matches rs, or matches rt with UsesRt=1.
REQ-018 SHALL raise a branch-on-ALU hazard when the instruction is BrRR/BrR, RegWrite_IDEX=1, MemRead_IDEX=0 and RdAddr_IDEX matches a used source.
REQ-019 SHALL raise a branch-on-load-late hazard when the instruction is BrRR/BrR, MemRead_EXMEM=1 and RdAddr_EXMEM matches a used source.
REQ-020 SHALL raise a branch-on-load-early hazard when the instruction is BrRR/BrR, MemRead_IDEX=1 and RdAddr_IDEX matches a used source; this hazard requires 2 stall cycles.
REQ-021 SHALL assert Stall combinationally, in the same cycle, whenever any hazard is raised in RUN, or whenever the state is STALL2.
REQ-022 SHALL drive PCWrite=0, IFIDWrite=0 and IDEXBubble=1 while Stall is 1, and PCWrite=1, IFIDWrite=1 and IDEXBubble=0 otherwise.
REQ-023 SHALL transition RUN->STALL2 on a branch-on-load-early hazard, and STALL2->RUN unconditionally after 1 cycle.
REQ-024 SHALL ignore BranchTaken while Stall=1, because the branch is not resolved.
REQ-025 SHALL, in RUN with Stall=0, assert IFIDFlush=1 combinationally and transition to FLUSH when BranchTaken=1 or Jmp=1.
REQ-026 SHALL hold IFIDFlush=0 in FLUSH and return FLUSH->RUN after 1 cycle; hazards are evaluated in FLUSH exactly as in RUN.
REQ-027 SHALL force PCWrite=0, IFIDWrite=0, IDEXBubble=0 and IFIDFlush=0 while Freeze=1, hold the state, and increment no counter.
REQ-028 SHALL increment StallCount by 1 for each cycle with Stall=1 and Freeze=0, saturating at all-ones.
REQ-029 SHALL increment FlushCount by 1 for each cycle with IFIDFlush=1, saturating at all-ones.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set State=RUN and StallCount=FlushCount=0, overriding Freeze and any in-progress STALL2 or FLUSH.
REQ-031 SHALL drive PCWrite=0, IFIDWrite=0, IDEXBubble=1 and IFIDFlush=1 while rst=1.

Structure
REQ-032 SHALL place the state encoding and the opcode constants 0x00/0x01/0x02/0x03/0x04/0x05/0x06/0x07/0x2B in a shared pipeline package, shared with the forwarding logic.
REQ-033 SHALL implement hazard classification as one combinational sub-module, hazard_detect; the FSM and counters remain in this module.

Verification
REQ-034 SHALL cover load-use: lw $2 in ID/EX, add rs=$2 in IF/ID -> 1 cycle with PCWrite=0 and IDEXBubble=1; StallCount=1.
REQ-035 SHALL cover branch-on-load-early: lw $3 in ID/EX, beq rs=$3 -> 2 stall cycles with State sequence RUN,STALL2,RUN; StallCount=2.
REQ-036 SHALL cover register 0: lw $0 in ID/EX, add rs=$0 -> no stall; StallCount stays 0.
REQ-037 SHALL cover a taken branch and a jump: BranchTaken=1 with no hazard -> IFIDFlush=1 for 1 cycle and State=FLUSH next cycle; Opcode=0x02 -> same; FlushCount=2.
REQ-038 SHALL cover Freeze during STALL2: State held at STALL2 and counters unchanged; after release, 1 more stall cycle.
REQ-039 SHALL cover reset in STALL2 with StallCount=5: next cycle State=RUN and StallCount=0.
